// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: valid/ready data bus between dmem_ctrl (master) and data memory (slave).
interface dmem_ctrl_if #(parameter int XLEN = 32);
    logic            req_v;
    logic            req_rdy;
    logic [XLEN-1:0] req_adr;
    logic            req_we;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_v;
    logic [XLEN-1:0] rsp_rdata;
    modport master (output req_v, req_adr, req_we, req_be, req_wdata, input req_rdy, rsp_v, rsp_rdata);
    modport slave (input req_v, req_adr, req_we, req_be, req_wdata, output req_rdy, rsp_v, rsp_rdata);
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: runs execute's load/store on the data bus, one access in flight, stalling until done.
module dmem_ctrl #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            stall_o,
    output logic            misalign_o,
    dmem_ctrl_if.master     bus
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t state, state_nxt;
    logic legal, accept;
    logic [1:0] adr_lo_q;
    logic [2:0] size_q;
    logic [3:0] be;
    logic [XLEN-1:0] wdata, mask;
    always_comb begin
        legal = (access_size_i == 3'b001) |
                (access_size_i == 3'b010 & ~adr_i[0]) |
                (access_size_i == 3'b100 & adr_i[1:0] == 2'b00);
        accept = state == IDLE & adr_v_i & legal;
        be = access_size_i[0] ? 4'b0001 << adr_i[1:0] : access_size_i[1] ? 4'b0011 << adr_i[1:0] : 4'b1111;
        wdata = access_size_i[0] ? {4{store_data_i[7:0]}} : access_size_i[1] ? {2{store_data_i[15:0]}} : store_data_i;
        mask = size_q[0] ? XLEN'(32'hFF) : size_q[1] ? XLEN'(32'hFFFF) : '1;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = accept ? REQ : IDLE;
            REQ:  state_nxt = bus.req_rdy ? RSP : REQ;
            RSP:  state_nxt = bus.rsp_v ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.req_v = state == REQ;
        stall_o = accept | state == REQ | (state == RSP & ~bus.rsp_v);
        misalign_o = state == IDLE & adr_v_i & ~legal;
        // stores complete on the same rsp_v but return no data
        load_data_o = (state == RSP & bus.rsp_v & ~bus.req_we) ? (bus.rsp_rdata >> {adr_lo_q, 3'b000}) & mask : '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            adr_lo_q      <= '0;
            size_q        <= '0;
            bus.req_adr   <= '0;
            bus.req_we    <= 1'b0;
            bus.req_be    <= '0;
            bus.req_wdata <= '0;
        end else if (accept) begin
            adr_lo_q      <= adr_i[1:0];
            size_q        <= access_size_i;
            bus.req_adr   <= {adr_i[XLEN-1:2], 2'b00};
            bus.req_we    <= is_store_i;
            bus.req_be    <= be;
            bus.req_wdata <= wdata;
        end
endmodule
